// File: rtl/mvm_pkg.sv
// Shared constants and types for the UART <-> MVM sequencer.
// Holds the default matrix/vector geometry, the derived bus widths and word counts,
// and the sequencer state encoding.
package mvm_pkg;

    localparam int R             = 2;
    localparam int C             = 2;
    localparam int W_X           = 4;
    localparam int W_K           = 4;
    localparam int W_Y_OUT       = 8;
    localparam int BITS_PER_WORD = 8;

    localparam int W_BUS_KX   = R * C * W_K + C * W_X;
    localparam int W_BUS_Y    = R * W_Y_OUT;
    localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
    localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_t;

endpackage

// File: rtl/mvm_seq_ctrl.sv
// Sequencer between the UART byte stream and the MVM datapath: packs received bytes
// into kx_bus, pulses mvm_start, latches y_bus on mvm_done and streams it back out.
// Latency: mvm_start the cycle after the last operand byte; m_valid the cycle after mvm_done.
// Backpressure: s_ready is high only while collecting; m_valid/m_data hold until m_ready.
//
// Ports: clk/rstn (async active-low reset); s_valid/s_ready/s_data byte input;
// kx_bus operand output {k, x}; mvm_start/mvm_done/y_bus MVM handshake;
// m_valid/m_ready/m_data byte output; busy and sticky ovf status.
// Optional macro MVM_SEQ_CTRL_TIMEOUT_EN adds an inter-byte timeout that discards a
// partial frame and pulses the extra output port 'timeout'.
module mvm_seq_ctrl #(
    parameter int R             = mvm_pkg::R,
    parameter int C             = mvm_pkg::C,
    parameter int W_X           = mvm_pkg::W_X,
    parameter int W_K           = mvm_pkg::W_K,
    parameter int W_Y_OUT       = mvm_pkg::W_Y_OUT,
    parameter int BITS_PER_WORD = mvm_pkg::BITS_PER_WORD,
`ifdef MVM_SEQ_CTRL_TIMEOUT_EN
    parameter int TIMEOUT_CLKS  = 4096,
`endif
    localparam int W_BUS_KX     = R * C * W_K + C * W_X,
    localparam int W_BUS_Y      = R * W_Y_OUT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [BITS_PER_WORD-1:0] s_data,
    output logic [W_BUS_KX-1:0]      kx_bus,
    output logic                     mvm_start,
    input  logic                     mvm_done,
    input  logic [W_BUS_Y-1:0]       y_bus,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [BITS_PER_WORD-1:0] m_data,
    output logic                     busy,
    output logic                     ovf
`ifdef MVM_SEQ_CTRL_TIMEOUT_EN
    ,
    output logic                     timeout
`endif
);

    import mvm_pkg::*;

    localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
    localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;
    localparam int N_MAX      = (N_WORDS_KX > N_WORDS_Y) ? N_WORDS_KX : N_WORDS_Y;
    localparam int CNT_W      = $clog2(N_MAX + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [W_BUS_KX-1:0]  kx_q, kx_d;
    logic [W_BUS_Y-1:0]   y_q, y_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     tx_idx;

`ifdef MVM_SEQ_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS);
    logic [TW-1:0]        idle_q, idle_d;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RECV;
            cnt_q   <= '0;
            kx_q    <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
`ifdef MVM_SEQ_CTRL_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kx_q    <= kx_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
`ifdef MVM_SEQ_CTRL_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kx_d      = kx_q;
        y_d       = y_q;
        s_ready   = 1'b0;
        mvm_start = 1'b0;
        m_valid   = 1'b0;
`ifdef MVM_SEQ_CTRL_TIMEOUT_EN
        idle_d    = '0;
        timeout   = 1'b0;
`endif

        case (state_q)
            RECV: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    kx_d[cnt_q*BITS_PER_WORD +: BITS_PER_WORD] = s_data;
                    if (cnt_q == CNT_W'(N_WORDS_KX - 1)) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef MVM_SEQ_CTRL_TIMEOUT_EN
                // An accepted byte always beats the timeout: idle_d stays 0 and the
                // byte is stored above.
                else if (cnt_q != '0) begin
                    if (idle_q == TW'(TIMEOUT_CLKS - 1)) begin
                        timeout = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
`endif
            end
            START: begin
                mvm_start = 1'b1;
                // A zero-latency MVM may complete in the launch cycle itself.
                if (mvm_done) begin
                    y_d     = y_bus;
                    state_d = SEND;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mvm_done) begin
                    y_d     = y_bus;
                    state_d = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (cnt_q == CNT_W'(N_WORDS_Y - 1)) begin
                        cnt_d   = '0;
                        state_d = RECV;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RECV;
        endcase
    end

    // A byte offered while not collecting is dropped and flagged until reset.
    assign ovf_d = ovf_q | (s_valid & ~s_ready);

    // Outside SEND the counter can exceed the result word range; clamp the select.
    always_comb begin
        tx_idx = (cnt_q < CNT_W'(N_WORDS_Y)) ? cnt_q : '0;
        m_data = y_q[tx_idx*BITS_PER_WORD +: BITS_PER_WORD];
    end

    assign kx_bus = kx_q;
    assign ovf    = ovf_q;
    assign busy   = !((state_q == RECV) && (cnt_q == '0));

endmodule
